mc_controller: RTL and testbench

- Multi-cycle hardwired controller for the MIPS-subset datapath. It replaces the single-cycle combinational decoder with a sequencer of IF/ID/EX/MEM/WB/HALT states.
- It drives per-state strobes for PC, IR, memory, ALU mux and register file, and performs handshakes with memory through mem_ready.
- It adds syscall halt/resume, an illegal-opcode flag and a retired-instruction counter.

---
 rtl/mc_controller.sv | 246 ++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// mc_controller -- multi-cycle hardwired sequencer for the MIPS-subset datapath.
//
// Steps each instruction through IF / ID / EX / MEM / WB (plus HALT for
// syscall) and drives the per-state datapath strobes.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   op, func        instruction fields from IR (stable from ID until IF)
//   alu_zero        ALU result == 0 (EX)
//   alu_ltez        rs signed <= 0 (EX)
//   mem_ready       memory access completes this cycle
//   go              resume pulse, only honoured in HALT
//   pc_write/pc_src PC load strobe and source (0 PC+4, 1 branch, 2 jump, 3 rs)
//   ir_write        latch instruction word
//   mem_read/write  memory requests; byte_en selects byte access
//   reg_write, memtoreg, regdst, jal   register-file write controls
//   alusrc, signedext, srav            ALU operand controls
//   state, halted   current state code and HALT indicator
//   illegal         one-cycle pulse in ID on an undecodable instruction
//   retired         retired-instruction counter (wraps)
module mc_controller #(
  parameter int CNT_W         = 32,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             alu_zero,
  input  logic             alu_ltez,
  input  logic             mem_ready,
  input  logic             go,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic             byte_en,
  output logic             reg_write,
  output logic             memtoreg,
  output logic             regdst,
  output logic             jal,
  output logic             alusrc,
  output logic             signedext,
  output logic             srav,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  // Codes 6 and 7 are named so the register can hold them; both recover to IF.
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_BAD6 = 3'd6,
    S_BAD7 = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;

  // ---------------------------------------------------------------------------
  // Instruction class decode
  // ---------------------------------------------------------------------------
  logic is_special, is_rtype, is_jr, is_sys, is_j, is_jal;
  logic is_beq, is_bne, is_blez, is_branch;
  logic is_aluimm, is_aluimm_sx, is_lw, is_lbu, is_sw, is_sb;
  logic is_load, is_store, is_legal;

  always_comb begin
    is_special   = (op == 6'b000000);
    is_jr        = is_special && (func == 6'b001000);
    is_sys       = is_special && (func == 6'b001100);
    is_rtype     = is_special && !is_jr && !is_sys;
    is_j         = (op == 6'b000010);
    is_jal       = (op == 6'b000011);
    is_beq       = (op == 6'b000100);
    is_bne       = (op == 6'b000101);
    is_blez      = (op == 6'b000110);
    is_branch    = is_beq || is_bne || is_blez;
    // addi / addiu / slti take a sign-extended immediate
    is_aluimm_sx = (op == 6'b001000) || (op == 6'b001001) || (op == 6'b001010);
    // andi / ori / xori / lui take a zero-extended immediate
    is_aluimm    = is_aluimm_sx || (op == 6'b001100) || (op == 6'b001101) ||
                   (op == 6'b001110) || (op == 6'b001111);
    is_lw        = (op == 6'b100011);
    is_lbu       = (op == 6'b100100);
    is_sw        = (op == 6'b101011);
    is_sb        = (op == 6'b101000);
    is_load      = is_lw || is_lbu;
    is_store     = is_sw || is_sb;
    is_legal     = is_special || is_j || is_jal || is_branch ||
                   is_aluimm || is_load || is_store;
  end

  // ---------------------------------------------------------------------------
  // Next state and strobes
  // ---------------------------------------------------------------------------
  logic mem_done;
  logic decode_en;

  always_comb begin
    mem_done  = MEM_HANDSHAKE ? mem_ready : 1'b1;
    decode_en = (state_q == S_ID) || (state_q == S_EX) ||
                (state_q == S_MEM) || (state_q == S_WB);

    state_d   = state_q;
    retire    = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    ir_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    jal       = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = 2'd0;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        if (!is_legal) begin
          // Unknown instruction retires as a nop
          illegal = 1'b1;
          state_d = S_IF;
          retire  = 1'b1;
        end else if (is_j) begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          state_d  = S_IF;
          retire   = 1'b1;
        end else if (is_jal) begin
          pc_write  = 1'b1;
          pc_src    = 2'd2;
          reg_write = 1'b1;
          jal       = 1'b1;
          state_d   = S_IF;
          retire    = 1'b1;
        end else if (is_jr) begin
          pc_write = 1'b1;
          pc_src   = 2'd3;
          state_d  = S_IF;
          retire   = 1'b1;
        end else if (is_sys) begin
          state_d = S_HALT;
          retire  = 1'b1;
        end else begin
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (is_branch) begin
          pc_write = (is_beq && alu_zero) || (is_bne && !alu_zero) ||
                     (is_blez && alu_ltez);
          pc_src   = 2'd1;
          state_d  = S_IF;
          retire   = 1'b1;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // Strobe is held until the access is accepted; only that cycle counts
        mem_read  = is_load;
        mem_write = is_store;
        if (mem_done) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            state_d = S_IF;
            retire  = 1'b1;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        state_d   = S_IF;
        retire    = 1'b1;
      end
      S_HALT: begin
        if (go) state_d = S_IF;
      end
      default: begin
        state_d = S_IF;
      end
    endcase

    alusrc    = decode_en && (is_aluimm || is_load || is_store);
    signedext = decode_en && (is_aluimm_sx || is_load || is_store);
    regdst    = decode_en && is_rtype;
    srav      = decode_en && is_rtype && (func == 6'b000111);
    byte_en   = decode_en && (is_lbu || is_sb);
    memtoreg  = decode_en && is_load;

    // Reset overrides everything so an in-flight access is dropped at once
    if (rst) begin
      pc_write  = 1'b0;
      pc_src    = 2'd0;
      ir_write  = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      jal       = 1'b0;
      illegal   = 1'b0;
      alusrc    = 1'b0;
      signedext = 1'b0;
      regdst    = 1'b0;
      srav      = 1'b0;
      byte_en   = 1'b0;
      memtoreg  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State and retired-counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IF;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == S_HALT) && !rst;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op, func;
  logic        alu_zero, alu_ltez, mem_ready, go;

  logic        pc_write, ir_write, mem_read, mem_write, byte_en, reg_write;
  logic        memtoreg, regdst, jal, alusrc, signedext, srav, halted, illegal;
  logic [1:0]  pc_src;
  logic [2:0]  state;
  logic [31:0] retired;

  logic        pc_write2, ir_write2, mem_read2, mem_write2, byte_en2, reg_write2;
  logic        memtoreg2, regdst2, jal2, alusrc2, signedext2, srav2, halted2, illegal2;
  logic [1:0]  pc_src2;
  logic [2:0]  state2;
  logic [1:0]  retired2;

  int checks = 0;
  int errors = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  mc_controller #(.CNT_W(32), .MEM_HANDSHAKE(1'b1)) dut (
    .clk(clk), .rst(rst), .op(op), .func(func), .alu_zero(alu_zero),
    .alu_ltez(alu_ltez), .mem_ready(mem_ready), .go(go),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .byte_en(byte_en),
    .reg_write(reg_write), .memtoreg(memtoreg), .regdst(regdst), .jal(jal),
    .alusrc(alusrc), .signedext(signedext), .srav(srav), .state(state),
    .halted(halted), .illegal(illegal), .retired(retired)
  );

  mc_controller #(.CNT_W(2), .MEM_HANDSHAKE(1'b1)) dut2 (
    .clk(clk), .rst(rst), .op(op), .func(func), .alu_zero(alu_zero),
    .alu_ltez(alu_ltez), .mem_ready(mem_ready), .go(go),
    .pc_write(pc_write2), .pc_src(pc_src2), .ir_write(ir_write2),
    .mem_read(mem_read2), .mem_write(mem_write2), .byte_en(byte_en2),
    .reg_write(reg_write2), .memtoreg(memtoreg2), .regdst(regdst2), .jal(jal2),
    .alusrc(alusrc2), .signedext(signedext2), .srav(srav2), .state(state2),
    .halted(halted2), .illegal(illegal2), .retired(retired2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; op = 6'd0; func = 6'd0; alu_zero = 1'b0; alu_ltez = 1'b0;
    mem_ready = 1'b0; go = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    exp_ret = 0;
  endtask

  // IF with immediate completion, instruction fields presented for ID onward
  task automatic fetch(input logic [5:0] o, input logic [5:0] f);
    op = o; func = f; mem_ready = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; op = 6'd0; func = 6'd0; alu_zero = 1'b0; alu_ltez = 1'b0;
    mem_ready = 1'b1; go = 1'b0;
    tick();
    checks++;
    if (state !== 3'd0 || halted !== 1'b0 || mem_read !== 1'b0 || ir_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold state=%0d halted=%0d mem_read=%0d ir_write=%0d, need 0 0 0 0",
               state, halted, mem_read, ir_write);
    end
    rst = 1'b0; mem_ready = 1'b0;
    #1;
    checks++;
    if (state !== 3'd0 || retired !== 32'd0 || mem_read !== 1'b1) begin
      errors++;
      $display("FAIL reset_release state=%0d retired=%0d mem_read=%0d, need 0 0 1",
               state, retired, mem_read);
    end
    exp_ret = 0;
  endtask

  task automatic test_alu;
    op = 6'd0; func = 6'b100000; mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || ir_write !== 1'b1 || pc_write !== 1'b1 || pc_src !== 2'd0 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL add_if state=%0d ir_write=%0d pc_write=%0d pc_src=%0d reg_write=%0d, need 0 1 1 0 0",
               state, ir_write, pc_write, pc_src, reg_write);
    end
    tick();
    checks++;
    if (state !== 3'd1 || reg_write !== 1'b0 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL add_id state=%0d reg_write=%0d pc_write=%0d, need 1 0 0", state, reg_write, pc_write);
    end
    tick();
    checks++;
    if (state !== 3'd2 || reg_write !== 1'b0 || alusrc !== 1'b0) begin
      errors++;
      $display("FAIL add_ex state=%0d reg_write=%0d alusrc=%0d, need 2 0 0", state, reg_write, alusrc);
    end
    tick();
    checks++;
    if (state !== 3'd4 || reg_write !== 1'b1 || regdst !== 1'b1 || memtoreg !== 1'b0) begin
      errors++;
      $display("FAIL add_wb state=%0d reg_write=%0d regdst=%0d memtoreg=%0d, need 4 1 1 0",
               state, reg_write, regdst, memtoreg);
    end
    tick();
    exp_ret++;
    checks++;
    if (state !== 3'd0 || retired !== 32'(exp_ret) || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL add_done state=%0d retired=%0d reg_write=%0d, need 0 %0d 0",
               state, retired, reg_write, exp_ret);
    end
  endtask

  task automatic test_load;
    fetch(6'b100011, 6'd0);
    tick();
    checks++;
    if (state !== 3'd2 || alusrc !== 1'b1 || signedext !== 1'b1) begin
      errors++;
      $display("FAIL lw_ex state=%0d alusrc=%0d signedext=%0d, need 2 1 1", state, alusrc, signedext);
    end
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (state !== 3'd3 || mem_read !== 1'b1 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
        errors++;
        $display("FAIL lw_mem_wait%0d state=%0d mem_read=%0d reg_write=%0d mem_write=%0d, need 3 1 0 0",
                 i, state, mem_read, reg_write, mem_write);
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 3'd3 || mem_read !== 1'b1) begin
      errors++;
      $display("FAIL lw_mem_done state=%0d mem_read=%0d, need 3 1", state, mem_read);
    end
    tick();
    checks++;
    if (state !== 3'd4 || reg_write !== 1'b1 || memtoreg !== 1'b1 || regdst !== 1'b0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL lw_wb state=%0d reg_write=%0d memtoreg=%0d regdst=%0d mem_read=%0d, need 4 1 1 0 0",
               state, reg_write, memtoreg, regdst, mem_read);
    end
    tick();
    exp_ret++;
    checks++;
    if (state !== 3'd0 || retired !== 32'(exp_ret)) begin
      errors++;
      $display("FAIL lw_done state=%0d retired=%0d, need 0 %0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_branch;
    alu_zero = 1'b1;
    fetch(6'b000100, 6'd0);
    tick();
    checks++;
    if (state !== 3'd2 || pc_write !== 1'b1 || pc_src !== 2'd1) begin
      errors++;
      $display("FAIL beq_taken state=%0d pc_write=%0d pc_src=%0d, need 2 1 1", state, pc_write, pc_src);
    end
    tick();
    exp_ret++;
    fetch(6'b000101, 6'd0);
    tick();
    checks++;
    if (state !== 3'd2 || pc_write !== 1'b0 || pc_src !== 2'd1) begin
      errors++;
      $display("FAIL bne_not_taken state=%0d pc_write=%0d pc_src=%0d, need 2 0 1", state, pc_write, pc_src);
    end
    tick();
    exp_ret++;
    checks++;
    if (state !== 3'd0 || retired !== 32'(exp_ret)) begin
      errors++;
      $display("FAIL branch_done state=%0d retired=%0d, need 0 %0d", state, retired, exp_ret);
    end
    alu_zero = 1'b0;
    // blez taken via alu_ltez
    alu_ltez = 1'b1;
    fetch(6'b000110, 6'd0);
    tick();
    checks++;
    if (pc_write !== 1'b1 || pc_src !== 2'd1) begin
      errors++;
      $display("FAIL blez_taken pc_write=%0d pc_src=%0d, need 1 1", pc_write, pc_src);
    end
    tick();
    exp_ret++;
    alu_ltez = 1'b0;
  endtask

  task automatic test_jump;
    go = 1'b1;  // must be ignored outside HALT
    fetch(6'b000011, 6'd0);
    checks++;
    if (state !== 3'd1 || pc_write !== 1'b1 || pc_src !== 2'd2 || reg_write !== 1'b1 || jal !== 1'b1) begin
      errors++;
      $display("FAIL jal_id state=%0d pc_write=%0d pc_src=%0d reg_write=%0d jal=%0d, need 1 1 2 1 1",
               state, pc_write, pc_src, reg_write, jal);
    end
    tick();
    exp_ret++;
    fetch(6'b000000, 6'b001000);
    checks++;
    if (pc_write !== 1'b1 || pc_src !== 2'd3 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL jr_id pc_write=%0d pc_src=%0d reg_write=%0d, need 1 3 0", pc_write, pc_src, reg_write);
    end
    tick();
    exp_ret++;
    go = 1'b0;
    checks++;
    if (state !== 3'd0 || retired !== 32'(exp_ret)) begin
      errors++;
      $display("FAIL jump_done state=%0d retired=%0d, need 0 %0d", state, retired, exp_ret);
    end
  endtask

  task automatic test_syscall;
    fetch(6'b000000, 6'b001100);
    tick();
    exp_ret++;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (state !== 3'd5 || halted !== 1'b1 || mem_read !== 1'b0 || pc_write !== 1'b0 ||
          retired !== 32'(exp_ret)) begin
        errors++;
        $display("FAIL halt_cycle%0d state=%0d halted=%0d mem_read=%0d pc_write=%0d retired=%0d, need 5 1 0 0 %0d",
                 i, state, halted, mem_read, pc_write, retired, exp_ret);
      end
      if (i == 9) go = 1'b1;
      tick();
    end
    go = 1'b0;
    checks++;
    if (state !== 3'd0 || halted !== 1'b0 || retired !== 32'(exp_ret)) begin
      errors++;
      $display("FAIL halt_resume state=%0d halted=%0d retired=%0d, need 0 0 %0d",
               state, halted, retired, exp_ret);
    end
  endtask

  task automatic test_illegal;
    fetch(6'b111111, 6'd0);
    checks++;
    if (state !== 3'd1 || illegal !== 1'b1 || reg_write !== 1'b0 || mem_write !== 1'b0 || pc_write !== 1'b0) begin
      errors++;
      $display("FAIL illegal_id state=%0d illegal=%0d reg_write=%0d mem_write=%0d pc_write=%0d, need 1 1 0 0 0",
               state, illegal, reg_write, mem_write, pc_write);
    end
    tick();
    exp_ret++;
    checks++;
    if (state !== 3'd0 || illegal !== 1'b0 || retired !== 32'(exp_ret)) begin
      errors++;
      $display("FAIL illegal_after state=%0d illegal=%0d retired=%0d, need 0 0 %0d",
               state, illegal, retired, exp_ret);
    end
  endtask

  task automatic test_store_reset;
    // Full sb with ready: 4 cycles, byte access
    fetch(6'b101000, 6'd0);
    tick();
    tick();
    checks++;
    if (state !== 3'd3 || mem_write !== 1'b1 || byte_en !== 1'b1 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL sb_mem state=%0d mem_write=%0d byte_en=%0d mem_read=%0d, need 3 1 1 0",
               state, mem_write, byte_en, mem_read);
    end
    tick();
    exp_ret++;
    checks++;
    if (state !== 3'd0 || retired !== 32'(exp_ret)) begin
      errors++;
      $display("FAIL sb_done state=%0d retired=%0d, need 0 %0d", state, retired, exp_ret);
    end
    // sw stalled in MEM, then reset
    fetch(6'b101011, 6'd0);
    tick();
    mem_ready = 1'b0;
    tick();
    checks++;
    if (state !== 3'd3 || mem_write !== 1'b1) begin
      errors++;
      $display("FAIL sw_stall state=%0d mem_write=%0d, need 3 1", state, mem_write);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || state !== 3'd0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL sw_reset_drop mem_write=%0d state=%0d mem_read=%0d, need 0 0 0",
               mem_write, state, mem_read);
    end
    tick();
    rst = 1'b0;
    #1;
    exp_ret = 0;
    checks++;
    if (state !== 3'd0 || retired !== 32'd0 || reg_write !== 1'b0) begin
      errors++;
      $display("FAIL sw_reset_release state=%0d retired=%0d reg_write=%0d, need 0 0 0",
               state, retired, reg_write);
    end
  endtask

  task automatic test_wrap;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      fetch(6'b111111, 6'd0);
      tick();
    end
    checks++;
    if (retired2 !== 2'd3 || retired !== 32'd3) begin
      errors++;
      $display("FAIL wrap_three retired2=%0d retired=%0d, need 3 3", retired2, retired);
    end
    fetch(6'b111111, 6'd0);
    tick();
    checks++;
    if (retired2 !== 2'd0 || retired !== 32'd4) begin
      errors++;
      $display("FAIL wrap_four retired2=%0d retired=%0d, need 0 4", retired2, retired);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_branch();
    test_jump();
    test_syscall();
    test_illegal();
    test_store_reset();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
